// File: rtl/pulse_gen_pkg.sv
// pulse_gen_pkg
//   Shared types and default parameter values for the push-button pulse
//   generator (pulse_gen).
//   - state_t : debounce FSM state encoding (2 bits)
//   - DEF_*   : default parameter values used by pulse_gen
//   Optional macro PULSE_GEN_REPEAT_EN adds the auto-repeat defaults.
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHK_HI = 2'd1,
        HIGH   = 2'd2,
        CHK_LO = 2'd3
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_PULSE_W         = 2;
    localparam int DEF_CNT_W           = 8;
`ifdef PULSE_GEN_REPEAT_EN
    localparam int DEF_HOLD_CYCLES     = 64;
    localparam int DEF_REPEAT_CYCLES   = 32;
`endif

endpackage

// File: rtl/pulse_gen_sync2.sv
// sync2
//   Two-flop synchroniser for a single asynchronous level.
//   Ports:
//     clk  - destination clock, rising edge
//     rst  - asynchronous active-high reset, both flops clear to 0
//     d    - asynchronous input
//     q    - synchronised output, 2 clk cycles after d
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pulse_gen.sv
// pulse_gen
//   Conditions a bouncing push-button into a debounced level and a
//   fixed-width registered count pulse for the downstream 4-bit counter.
//   Ports:
//     clk          - system clock, rising edge
//     rst          - asynchronous active-high reset
//     btn_raw      - raw, unsynchronised button (1 = pressed)
//     arm_i        - 1 = accepted presses generate pulses
//     pulse_o      - registered count pulse, PULSE_W cycles wide
//     level_o      - debounced button level
//     press_cnt_o  - pulses issued, wraps 15 -> 0
//   Optional macro PULSE_GEN_REPEAT_EN: while the button is held, an auto
//   pulse fires HOLD_CYCLES after the press and then every REPEAT_CYCLES.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | debounced level 0, waiting for btn_s = 1
//   CHK_HI | btn_s = 1, counting DEBOUNCE_CYCLES stable cycles
//   HIGH   | debounced level 1, waiting for btn_s = 0
//   CHK_LO | btn_s = 0, counting DEBOUNCE_CYCLES stable cycles
module pulse_gen
    import pulse_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int PULSE_W         = DEF_PULSE_W,
    parameter int CNT_W           = DEF_CNT_W
`ifdef PULSE_GEN_REPEAT_EN
    ,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic       arm_i,
    output logic       pulse_o,
    output logic       level_o,
    output logic [3:0] press_cnt_o
);

    // Down-counters: loaded with N-1, terminal count at 0, so a check
    // state lasts exactly N cycles.
    localparam logic [CNT_W-1:0] DB_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PW_LOAD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic             btn_s;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] db_cnt, db_cnt_nxt;
    logic [CNT_W-1:0] pw_cnt;
    logic             press_evt;
    logic             fire;

    sync2 u_sync2 (
        .clk (clk),
        .rst (rst),
        .d   (btn_raw),
        .q   (btn_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            db_cnt  <= '0;
            level_o <= 1'b0;
        end else begin
            state   <= state_nxt;
            db_cnt  <= db_cnt_nxt;
            level_o <= (state_nxt == HIGH) || (state_nxt == CHK_LO);
        end
    end

    always_comb begin
        state_nxt  = state;
        db_cnt_nxt = db_cnt;
        press_evt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (btn_s) begin
                    state_nxt  = CHK_HI;
                    db_cnt_nxt = DB_LOAD;
                end
            end
            CHK_HI: begin
                if (!btn_s) begin
                    state_nxt = IDLE;
                end else if (db_cnt == '0) begin
                    state_nxt = HIGH;
                    press_evt = 1'b1;
                end else begin
                    db_cnt_nxt = db_cnt - ONE;
                end
            end
            HIGH: begin
                if (!btn_s) begin
                    state_nxt  = CHK_LO;
                    db_cnt_nxt = DB_LOAD;
                end
            end
            CHK_LO: begin
                if (btn_s) begin
                    state_nxt = HIGH;
                end else if (db_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    db_cnt_nxt = db_cnt - ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef PULSE_GEN_REPEAT_EN
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_LOAD  = CNT_W'(REPEAT_CYCLES - 1);

    logic [CNT_W-1:0] rpt_cnt;
    logic             auto_evt;

    // The timer only advances in HIGH, so a CHK_LO excursion pauses it;
    // a fresh press always reloads it, which cancels any stale count.
    assign auto_evt = (state == HIGH) && (rpt_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_cnt <= '0;
        end else if (press_evt) begin
            rpt_cnt <= HOLD_LOAD;
        end else if (state == HIGH) begin
            rpt_cnt <= (rpt_cnt == '0) ? RPT_LOAD : (rpt_cnt - ONE);
        end else if (state_nxt == IDLE) begin
            rpt_cnt <= '0;
        end
    end

    assign fire = (press_evt || auto_evt) && arm_i && !pulse_o;
`else
    assign fire = press_evt && arm_i && !pulse_o;
`endif

    // Events arriving while pulse_o is high (including its last cycle) are
    // dropped, which also guarantees at least one low cycle between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_o     <= 1'b0;
            pw_cnt      <= '0;
            press_cnt_o <= 4'd0;
        end else if (fire) begin
            pulse_o     <= 1'b1;
            pw_cnt      <= PW_LOAD;
            press_cnt_o <= press_cnt_o + 4'd1;
        end else if (pulse_o) begin
            if (pw_cnt == '0) begin
                pulse_o <= 1'b0;
            end else begin
                pw_cnt <= pw_cnt - ONE;
            end
        end
    end

endmodule
